xrv_pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the xriscv fetch/decode/execute path. It decides every cycle whether decode holds, flushes or runs, and whether fetch is redirected. Redirect sources are a JAL resolved in decode and a taken branch or JALR resolved in execute. It also detects load-use hazards between the instruction in execute and the one in decode, and stalls decode until the LSU returns data.

---
 rtl/xrv_pipe_ctrl_if.sv | 41 ++++
 rtl/xrv_pipe_ctrl.sv | 169 ++++++++++++++++
 tb/tb_xrv_pipe_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/xrv_pipe_ctrl_if.sv
// Handshake and status bundle between the xriscv fetch/decode/execute stages and the
// pipeline sequencing controller (xrv_pipe_ctrl).
interface xrv_pipe_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_src1;
  logic [4:0]  id_src2;
  logic        id_uses_src1;
  logic        id_uses_src2;
  logic        id_jmp;
  logic [31:0] id_jmp_addr;
  logic        ex_valid;
  logic        ex_is_load;
  logic [4:0]  ex_dest;
  logic        ex_redirect;
  logic [31:0] ex_redirect_addr;
  logic        lsu_done;
  logic        flush;
  logic        id_stall;
  logic        fetch_redirect;
  logic [31:0] fetch_redirect_addr;
  logic        fetch_kill;
  logic        err_timeout;
  logic [1:0]  state;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  // master: the pipeline stages; slave: the sequencing controller
  modport master (
    output id_valid, id_src1, id_src2, id_uses_src1, id_uses_src2, id_jmp, id_jmp_addr,
    output ex_valid, ex_is_load, ex_dest, ex_redirect, ex_redirect_addr, lsu_done,
    input  flush, id_stall, fetch_redirect, fetch_redirect_addr, fetch_kill,
    input  err_timeout, state, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_uses_src1, id_uses_src2, id_jmp, id_jmp_addr,
    input  ex_valid, ex_is_load, ex_dest, ex_redirect, ex_redirect_addr, lsu_done,
    output flush, id_stall, fetch_redirect, fetch_redirect_addr, fetch_kill,
    output err_timeout, state, perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/xrv_pipe_ctrl.sv
// Pipeline sequencing controller: load-use stalls, redirect/fetch-kill sequencing, stall timeout.
// Optional performance counters are built when XRV_PIPE_CTRL_PERF_EN is defined.
module xrv_pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned LOAD_TIMEOUT = 255
) (
  input logic          clk,
  input logic          rstb,
  xrv_pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_REDIRECT   = 2'd2
  } state_t;

  localparam logic [3:0]  KILL_INIT  = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LIM = 16'(LOAD_TIMEOUT);
  // With a single-cycle kill the redirect cycle itself is the whole kill window
  localparam state_t REDIR_TARGET = (FLUSH_CYCLES == 1) ? ST_RUN : ST_REDIRECT;

  state_t      state_reg, state_next;
  logic [3:0]  kill_cnt_reg, kill_cnt_next;
  logic [15:0] load_cnt_reg, load_cnt_next;
  logic        err_reg, err_next;

  logic        kill_decode, stall_decode, redir, kill_fetch;
  logic [31:0] redir_addr;

  // Load-use hazard detection, one comparator per decode source operand
  logic [1:0][4:0] src_vec;
  logic [1:0]      use_vec;
  logic [1:0]      src_hit;
  logic            hazard;
  logic            jmp_req;

  assign src_vec = {bus.id_src2, bus.id_src1};
  assign use_vec = {bus.id_uses_src2, bus.id_uses_src1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = use_vec[gi] && (src_vec[gi] == bus.ex_dest);
    end
  endgenerate

  assign hazard  = bus.ex_valid && bus.ex_is_load && (bus.ex_dest != 5'd0) &&
                   bus.id_valid && (|src_hit);
  assign jmp_req = bus.id_jmp && bus.id_valid;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg    <= ST_RUN;
      kill_cnt_reg <= '0;
      load_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      kill_cnt_reg <= kill_cnt_next;
      load_cnt_reg <= load_cnt_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    kill_cnt_next = kill_cnt_reg;
    load_cnt_next = load_cnt_reg;
    err_next      = err_reg;
    if (bus.ex_redirect) begin
      state_next    = REDIR_TARGET;
      kill_cnt_next = KILL_INIT;
      load_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (hazard) begin
            state_next    = ST_LOAD_STALL;
            load_cnt_next = 16'd1;
          end else if (jmp_req) begin
            state_next    = REDIR_TARGET;
            kill_cnt_next = KILL_INIT;
          end
        end
        ST_LOAD_STALL: begin
          if (bus.lsu_done) begin
            state_next    = ST_RUN;
            load_cnt_next = '0;
          end else if (load_cnt_reg == TIMEOUT_LIM) begin
            state_next    = ST_RUN;
            load_cnt_next = '0;
            err_next      = 1'b1;
          end else begin
            load_cnt_next = load_cnt_reg + 16'd1;
          end
        end
        ST_REDIRECT: begin
          if (kill_cnt_reg <= 4'd1) begin
            state_next    = ST_RUN;
            kill_cnt_next = '0;
          end else begin
            kill_cnt_next = kill_cnt_reg - 4'd1;
          end
        end
        default: state_next = ST_RUN;
      endcase
    end
  end

  always_comb begin
    kill_decode  = 1'b0;
    stall_decode = 1'b0;
    redir        = 1'b0;
    redir_addr   = '0;
    kill_fetch   = 1'b0;
    if (bus.ex_redirect) begin
      kill_decode = 1'b1;
      redir       = 1'b1;
      redir_addr  = bus.ex_redirect_addr;
      kill_fetch  = 1'b1;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (hazard) begin
            stall_decode = 1'b1;
          end else if (jmp_req) begin
            redir      = 1'b1;
            redir_addr = bus.id_jmp_addr;
            kill_fetch = 1'b1;
          end
        end
        ST_LOAD_STALL: stall_decode = !bus.lsu_done && (load_cnt_reg != TIMEOUT_LIM);
        ST_REDIRECT:   kill_fetch   = 1'b1;
        default:       kill_fetch   = 1'b0;
      endcase
    end
  end

  assign bus.flush               = kill_decode;
  assign bus.id_stall            = stall_decode;
  assign bus.fetch_redirect      = redir;
  assign bus.fetch_redirect_addr = redir_addr;
  assign bus.fetch_kill          = kill_fetch;
  assign bus.err_timeout         = err_reg;
  assign bus.state               = state_reg;

`ifdef XRV_PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_reg;
  logic [31:0] perf_flush_reg;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      perf_stall_reg <= '0;
      perf_flush_reg <= '0;
    end else begin
      if (stall_decode) perf_stall_reg <= perf_stall_reg + 32'd1;
      if (kill_decode)  perf_flush_reg <= perf_flush_reg + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = perf_stall_reg;
  assign bus.perf_flush_cnt = perf_flush_reg;
`else
  assign bus.perf_stall_cnt = '0;
  assign bus.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_xrv_pipe_ctrl.sv
// Directed scoreboard bench for xrv_pipe_ctrl (FLUSH_CYCLES=2, LOAD_TIMEOUT=4).
// Expected outputs are queued per cycle as stimulus is applied and checked at the falling edge.
module tb_xrv_pipe_ctrl;

  localparam logic [1:0] RUN = 2'd0;
  localparam logic [1:0] LS  = 2'd1;
  localparam logic [1:0] RD  = 2'd2;

  typedef struct packed {
    logic        flush;
    logic        id_stall;
    logic        redir;
    logic [31:0] addr;
    logic        kill;
    logic        err;
    logic [1:0]  st;
  } exp_t;

  logic clk;
  logic rstb;
  int   checks;
  int   errors;
  int   step_no;
  int   stall_total;
  int   flush_total;
  exp_t sb[$];

  xrv_pipe_ctrl_if bus ();

  xrv_pipe_ctrl #(
    .FLUSH_CYCLES(2),
    .LOAD_TIMEOUT(4)
  ) dut (
    .clk (clk),
    .rstb(rstb),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic f, input logic s, input logic r, input logic [31:0] a,
                              input logic k, input logic e, input logic [1:0] st);
    exp_t x;
    x.flush = f; x.id_stall = s; x.redir = r; x.addr = a; x.kill = k; x.err = e; x.st = st;
    return x;
  endfunction

  // One cycle: queue the expectation, compare at negedge, advance to just after the next posedge
  task automatic step(input string tag, input exp_t e);
    exp_t got;
    sb.push_back(e);
    stall_total += int'(e.id_stall);
    flush_total += int'(e.flush);
    @(negedge clk);
    got = sb.pop_front();
    step_no++;
    chk({tag, ".flush"},    32'(bus.flush),          32'(got.flush));
    chk({tag, ".id_stall"}, 32'(bus.id_stall),       32'(got.id_stall));
    chk({tag, ".redirect"}, 32'(bus.fetch_redirect), 32'(got.redir));
    chk({tag, ".addr"},     bus.fetch_redirect_addr, got.addr);
    chk({tag, ".kill"},     32'(bus.fetch_kill),     32'(got.kill));
    chk({tag, ".err"},      32'(bus.err_timeout),    32'(got.err));
    chk({tag, ".state"},    32'(bus.state),          32'(got.st));
    $display("step %0d %s: flush=%b stall=%b redir=%b addr=%h kill=%b err=%b state=%0d",
             step_no, tag, bus.flush, bus.id_stall, bus.fetch_redirect,
             bus.fetch_redirect_addr, bus.fetch_kill, bus.err_timeout, bus.state);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_src1 = 0; bus.id_src2 = 0; bus.id_uses_src1 = 0;
    bus.id_uses_src2 = 0; bus.id_jmp = 0; bus.id_jmp_addr = 0; bus.ex_valid = 0;
    bus.ex_is_load = 0; bus.ex_dest = 0; bus.ex_redirect = 0; bus.ex_redirect_addr = 0;
    bus.lsu_done = 0;
  endtask

  task automatic set_hazard(input logic [4:0] rd);
    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_dest = rd;
    bus.id_valid = 1; bus.id_uses_src1 = 1; bus.id_src1 = rd;
  endtask

  task automatic check_perf(input string tag);
`ifdef XRV_PIPE_CTRL_PERF_EN
    chk({tag, ".perf_stall"}, bus.perf_stall_cnt, 32'(stall_total));
    chk({tag, ".perf_flush"}, bus.perf_flush_cnt, 32'(flush_total));
`else
    chk({tag, ".perf_stall"}, bus.perf_stall_cnt, 32'd0);
    chk({tag, ".perf_flush"}, bus.perf_flush_cnt, 32'd0);
`endif
  endtask

  initial begin
    checks = 0; errors = 0; step_no = 0; stall_total = 0; flush_total = 0;
    clear_inputs();
    rstb = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstb = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    step("reset", mk(0, 0, 0, 32'h0, 0, 0, RUN));
    check_perf("reset");

    // Load-use on rs1: three stall cycles, lsu_done in the fourth
    set_hazard(5'd5);
    step("lu0", mk(0, 1, 0, 32'h0, 0, 0, RUN));
    step("lu1", mk(0, 1, 0, 32'h0, 0, 0, LS));
    step("lu2", mk(0, 1, 0, 32'h0, 0, 0, LS));
    bus.lsu_done = 1;
    step("lu_done", mk(0, 0, 0, 32'h0, 0, 0, LS));
    clear_inputs();
    step("lu_run", mk(0, 0, 0, 32'h0, 0, 0, RUN));

    // Destination x0 never stalls
    set_hazard(5'd0);
    step("x0", mk(0, 0, 0, 32'h0, 0, 0, RUN));
    clear_inputs();

    // Hazard via rs2 only
    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_dest = 5'd7;
    bus.id_valid = 1; bus.id_uses_src2 = 1; bus.id_src2 = 5'd7; bus.id_src1 = 5'd7;
    step("rs2_0", mk(0, 1, 0, 32'h0, 0, 0, RUN));
    bus.lsu_done = 1;
    step("rs2_done", mk(0, 0, 0, 32'h0, 0, 0, LS));
    clear_inputs();
    step("rs2_run", mk(0, 0, 0, 32'h0, 0, 0, RUN));

    // Execute redirect, two-cycle kill
    bus.ex_redirect = 1; bus.ex_redirect_addr = 32'h0000_0100;
    step("exr0", mk(1, 0, 1, 32'h100, 1, 0, RUN));
    clear_inputs();
    step("exr1", mk(0, 0, 0, 32'h0, 1, 0, RD));
    step("exr2", mk(0, 0, 0, 32'h0, 0, 0, RUN));

    // JAL in decode: the JAL itself is not flushed
    bus.id_valid = 1; bus.id_jmp = 1; bus.id_jmp_addr = 32'h0000_2000;
    step("jal0", mk(0, 0, 1, 32'h2000, 1, 0, RUN));
    clear_inputs();
    step("jal1", mk(0, 0, 0, 32'h0, 1, 0, RD));
    step("jal2", mk(0, 0, 0, 32'h0, 0, 0, RUN));

    // JAL and execute redirect together: execute wins
    bus.id_valid = 1; bus.id_jmp = 1; bus.id_jmp_addr = 32'h0000_2000;
    bus.ex_redirect = 1; bus.ex_redirect_addr = 32'h0000_0300;
    step("both0", mk(1, 0, 1, 32'h300, 1, 0, RUN));
    clear_inputs();
    step("both1", mk(0, 0, 0, 32'h0, 1, 0, RD));
    step("both2", mk(0, 0, 0, 32'h0, 0, 0, RUN));

    // New redirect inside REDIRECT restarts the kill window; a JAL there is ignored
    bus.ex_redirect = 1; bus.ex_redirect_addr = 32'h0000_0400;
    step("rr0", mk(1, 0, 1, 32'h400, 1, 0, RUN));
    bus.ex_redirect_addr = 32'h0000_0500;
    step("rr1", mk(1, 0, 1, 32'h500, 1, 0, RD));
    clear_inputs();
    bus.id_valid = 1; bus.id_jmp = 1; bus.id_jmp_addr = 32'h0000_7000;
    step("rr2", mk(0, 0, 0, 32'h0, 1, 0, RD));
    clear_inputs();
    step("rr3", mk(0, 0, 0, 32'h0, 0, 0, RUN));

    // Redirect beats lsu_done in LOAD_STALL
    set_hazard(5'd9);
    step("lr0", mk(0, 1, 0, 32'h0, 0, 0, RUN));
    step("lr1", mk(0, 1, 0, 32'h0, 0, 0, LS));
    clear_inputs();
    bus.lsu_done = 1; bus.ex_redirect = 1; bus.ex_redirect_addr = 32'h0000_0600;
    step("lr2", mk(1, 0, 1, 32'h600, 1, 0, LS));
    clear_inputs();
    step("lr3", mk(0, 0, 0, 32'h0, 1, 0, RD));
    step("lr4", mk(0, 0, 0, 32'h0, 0, 0, RUN));

    // Load stall timeout (LOAD_TIMEOUT=4); JAL ignored while stalled
    set_hazard(5'd3);
    step("to0", mk(0, 1, 0, 32'h0, 0, 0, RUN));
    bus.id_jmp = 1; bus.id_jmp_addr = 32'h0000_8000;
    step("to1", mk(0, 1, 0, 32'h0, 0, 0, LS));
    step("to2", mk(0, 1, 0, 32'h0, 0, 0, LS));
    step("to3", mk(0, 1, 0, 32'h0, 0, 0, LS));
    step("to4", mk(0, 0, 0, 32'h0, 0, 0, LS));
    clear_inputs();
    step("to5", mk(0, 0, 0, 32'h0, 0, 1, RUN));
    step("to6", mk(0, 0, 0, 32'h0, 0, 1, RUN));
    check_perf("perf");

    // Asynchronous reset from LOAD_STALL, between clock edges
    set_hazard(5'd4);
    step("ar0", mk(0, 1, 0, 32'h0, 0, 1, RUN));
    chk("ar.pre_state", 32'(bus.state), 32'(LS));
    #2;
    rstb = 1'b0;
    bus.id_valid = 0;
    #1;
    chk("ar.state", 32'(bus.state), 32'(RUN));
    chk("ar.id_stall", 32'(bus.id_stall), 32'd0);
    chk("ar.err", 32'(bus.err_timeout), 32'd0);
    stall_total = 0;
    flush_total = 0;
    check_perf("ar");
    clear_inputs();
    @(posedge clk);
    #1 rstb = 1'b1;
    @(posedge clk);
    #1;
    step("post_reset", mk(0, 0, 0, 32'h0, 0, 0, RUN));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
